muldiv_iter: RTL

Parametrised iterative multiply/divide unit for the execute stage of the 5-stage pipeline. Performs signed/unsigned multiply and divide on `WIDTH`-bit operands and produces a `2*WIDTH`-bit HI/LO result for the HI/LO register write path. Raises a stall request while computing, and supports cancellation on flush. Also defines divide-by-zero and optional single-pass multiply behaviour.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/div_restore_step.sv | 22 ++
 rtl/muldiv_iter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the iteration counter width.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not borrow.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dividend_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             quot_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    assign shifted    = {rem_i, dividend_bit_i};
    assign diff       = shifted - {2'b00, divisor_i};
    // No borrow out of the top bit means the divisor fits into the partial remainder.
    assign quot_bit_o = ~diff[WIDTH+1];
    assign rem_o      = quot_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and divide for the execute stage; works on
// operand magnitudes and applies result signs in a final SIGN cycle.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q;
    logic [WIDTH:0]    rem_q;       // multiply: upper product half; divide: partial remainder
    logic [WIDTH-1:0]  acc_lo_q;    // multiply: multiplier/low product; divide: dividend/quotient
    logic [WIDTH-1:0]  mag_b_q;
    logic              neg_hi_q, neg_lo_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    logic              dbz_q;

    logic              accept;
    logic              sign_a, sign_b, start_dbz;
    logic [WIDTH-1:0]  abs_a, abs_b;

    assign accept    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i && !cancel_i;
    assign sign_a    = ~op_i[0] & a_i[WIDTH-1];
    assign sign_b    = ~op_i[0] & b_i[WIDTH-1];
    assign abs_a     = sign_a ? -a_i : a_i;
    assign abs_b     = sign_b ? -b_i : b_i;
    assign start_dbz = op_i[1] && (b_i == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    cnt_d = '0;
                    if (start_dbz)
                        state_d = ST_DONE;
                    else if (!op_i[1] && MUL_FAST)
                        state_d = ST_SIGN;
                    else
                        state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT)
                    state_d = ST_SIGN;
            end
            ST_SIGN: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (cancel_i)
            state_d = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shift-add multiply step: add the multiplicand when the current multiplier bit is set.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem;
    logic             div_qbit;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] acc_lo_d;

    assign mul_sum = {1'b0, rem_q[WIDTH-1:0]} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);

    div_restore_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i          (rem_q),
        .dividend_bit_i (acc_lo_q[WIDTH-1]),
        .divisor_i      (mag_b_q),
        .rem_o          (div_rem),
        .quot_bit_o     (div_qbit)
    );

    always_comb begin
        rem_d    = {1'b0, mul_sum[WIDTH:1]};
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        if (op_q[1]) begin
            rem_d    = div_rem;
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_qbit};
        end
    end

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   rem_signed, quot_signed;
    logic [WIDTH-1:0]   res_hi, res_lo;

    if (MUL_FAST) begin : g_fast_mul
        assign prod_mag = {{WIDTH{1'b0}}, acc_lo_q} * {{WIDTH{1'b0}}, mag_b_q};
    end else begin : g_iter_mul
        assign prod_mag = {rem_q[WIDTH-1:0], acc_lo_q};
    end

    assign prod_signed = neg_lo_q ? -prod_mag : prod_mag;
    assign rem_signed  = neg_hi_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    assign quot_signed = neg_lo_q ? -acc_lo_q : acc_lo_q;
    assign res_hi      = op_q[1] ? rem_signed  : prod_signed[2*WIDTH-1:WIDTH];
    assign res_lo      = op_q[1] ? quot_signed : prod_signed[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= OP_MULT;
            rem_q    <= '0;
            acc_lo_q <= '0;
            mag_b_q  <= '0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else if (!cancel_i) begin
            if (accept) begin
                op_q     <= op_i;
                rem_q    <= '0;
                acc_lo_q <= abs_a;
                mag_b_q  <= abs_b;
                neg_lo_q <= sign_a ^ sign_b;
                neg_hi_q <= op_i[1] ? sign_a : (sign_a ^ sign_b);
                if (start_dbz) begin
                    hi_q  <= a_i;
                    lo_q  <= '1;
                    dbz_q <= 1'b1;
                end
            end else if (state_q == ST_CALC) begin
                rem_q    <= rem_d;
                acc_lo_q <= acc_lo_d;
            end else if (state_q == ST_SIGN) begin
                hi_q  <= res_hi;
                lo_q  <= res_lo;
                dbz_q <= 1'b0;
            end
        end
    end

    assign busy_o = (state_q == ST_CALC) || (state_q == ST_SIGN) || accept;
    assign done_o = (state_q == ST_DONE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign dbz_o  = dbz_q;

endmodule
